// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM-stage load/store unit.
//   - access size encodings (SZ_BYTE, SZ_HALF, SZ_WORD; 2'b11 is illegal)
//   - FSM state enum of mem_access_unit
//   - is_misaligned(): fault check on a request's size and low address bits
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_MRG  = 3'd2,
      ST_WR   = 3'd3,
      ST_RESP = 3'd4
   } mem_state_e;

   // Halves need addr[0]=0, words need addr[1:0]=0; size 2'b11 always faults.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] offset);
      logic mis;
      case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = offset[0];
         SZ_WORD: mis = (offset != 2'b00);
         default: mis = 1'b1;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational big-endian lane logic for a 32-bit word.
// Ports:
//   word       in  32  word read from memory
//   offset     in  2   byte offset within the word (addr[1:0])
//   size       in  2   access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   sign_ext   in  1   sign-extend sub-word loads
//   wdata      in  32  store data, right-justified
//   load_data  out 32  selected lane, right-justified and extended
//   store_word out 32  word with the target lane replaced by wdata
// Offset 0 is the most significant byte (bits 31:24).
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane  = 8'h00;
      half_lane  = 16'h0000;
      load_data  = word;
      store_word = word;

      case (offset)
         2'd0: byte_lane = word[31:24];
         2'd1: byte_lane = word[23:16];
         2'd2: byte_lane = word[15:8];
         2'd3: byte_lane = word[7:0];
      endcase
      half_lane = offset[1] ? word[15:0] : word[31:16];

      case (size)
         SZ_BYTE: begin
            load_data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            case (offset)
               2'd0: store_word[31:24] = wdata[7:0];
               2'd1: store_word[23:16] = wdata[7:0];
               2'd2: store_word[15:8]  = wdata[7:0];
               2'd3: store_word[7:0]   = wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            load_data = {{16{sign_ext & half_lane[15]}}, half_lane};
            if (offset[1]) store_word[15:0]  = wdata[15:0];
            else           store_word[31:16] = wdata[15:0];
         end
         default: begin
            load_data  = word;
            store_word = wdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit in front of a word-addressed
// memory without byte enables. Sub-word stores become read-modify-write.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_write, req_size,      request: store flag, size, sign-extend,
//   req_signed, req_addr,     byte address, right-justified store data
//   req_wdata
//   resp_valid                one-cycle completion pulse
//   resp_rdata                load result (0 for stores and faults)
//   resp_misaligned           fault flag, qualified by resp_valid
//   mem_read, mem_read_address            read strobe / word index
//   mem_write, mem_write_address,         write strobe / word index / data
//   mem_write_data
//   mem_data                  read data, valid the cycle after mem_read
//
// Handshake: a request transfers on the posedge where req_valid && req_ready;
// req_ready is high only in IDLE, so a request held valid while the unit is
// busy waits until IDLE. All request fields are captured at that edge.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [1:0]       req_size,
   input  logic             req_signed,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             resp_valid,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             resp_misaligned,
   output logic             mem_read,
   output logic             mem_write,
   output logic [WIDTH-1:0] mem_read_address,
   output logic [WIDTH-1:0] mem_write_address,
   output logic [WIDTH-1:0] mem_write_data,
   input  logic [WIDTH-1:0] mem_data
);

   localparam int IDX = $clog2(DEPTH);

   mem_state_e       state_q, state_d;
   logic [IDX+1:0]   addr_q;
   logic [1:0]       size_q;
   logic             signed_q;
   logic             write_q;
   logic             mis_q;
   logic [WIDTH-1:0] wdata_q;
   logic [WIDTH-1:0] merge_q;
   logic [WIDTH-1:0] rdata_q;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] merged_word;
   logic [WIDTH-1:0] idx_ext;
   logic             req_mis;
   logic             accept;
   logic             unused_addr_hi;

   // Address bits above the word index wrap around and are not needed.
   assign unused_addr_hi = ^req_addr[WIDTH-1:IDX+2];
   assign idx_ext        = {{(WIDTH-IDX){1'b0}}, addr_q[IDX+1:2]};
   assign req_mis        = is_misaligned(req_size, req_addr[1:0]);
   assign accept         = req_valid && (state_q == ST_IDLE);

   mem_lane_align u_lane (
      .word       (mem_data),
      .offset     (addr_q[1:0]),
      .size       (size_q),
      .sign_ext   (signed_q),
      .wdata      (wdata_q),
      .load_data  (load_val),
      .store_word (merged_word)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q   <= '0;
         size_q   <= '0;
         signed_q <= 1'b0;
         write_q  <= 1'b0;
         mis_q    <= 1'b0;
         wdata_q  <= '0;
         merge_q  <= '0;
         rdata_q  <= '0;
      end else if (accept) begin
         addr_q   <= req_addr[IDX+1:0];
         size_q   <= req_size;
         signed_q <= req_signed;
         write_q  <= req_write;
         mis_q    <= req_mis;
         wdata_q  <= req_wdata;
         // Word stores skip the read, so the merge register starts as wdata.
         merge_q  <= req_wdata;
         rdata_q  <= '0;
      end else if (state_q == ST_MRG) begin
         if (write_q) merge_q <= merged_word;
         else         rdata_q <= load_val;
      end
   end

   always_comb begin
      state_d           = state_q;
      req_ready         = 1'b0;
      resp_valid        = 1'b0;
      mem_read          = 1'b0;
      mem_write         = 1'b0;
      mem_read_address  = '0;
      mem_write_address = '0;
      mem_write_data    = '0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_mis)                             state_d = ST_RESP;
               else if (req_write && req_size == SZ_WORD) state_d = ST_WR;
               else                                     state_d = ST_RD;
            end
         end
         ST_RD: begin
            mem_read         = 1'b1;
            mem_read_address = idx_ext;
            state_d          = ST_MRG;
         end
         ST_MRG: begin
            state_d = write_q ? ST_WR : ST_RESP;
         end
         ST_WR: begin
            // A reset landing on the write cycle suppresses the write, so the
            // memory never sees a partially completed store.
            if (!rst) begin
               mem_write         = 1'b1;
               mem_write_address = idx_ext;
               mem_write_data    = merge_q;
            end
            state_d = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign resp_rdata      = resp_valid ? rdata_q : '0;
   assign resp_misaligned = resp_valid && mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural memory, a reference model that
// predicts every output cycle from the access rules, directed scenarios
// with literal expectations, and a randomized phase.
module tb_mem_access_unit;

   localparam int W     = 32;
   localparam int DEPTH = 1024;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid, req_ready, req_write, req_signed;
   logic [1:0]   req_size;
   logic [W-1:0] req_addr, req_wdata;
   logic         resp_valid, resp_misaligned;
   logic [W-1:0] resp_rdata;
   logic         mem_read, mem_write;
   logic [W-1:0] mem_read_address, mem_write_address, mem_write_data;
   logic [W-1:0] mem_data;

   always #5 clk = ~clk;

   mem_access_unit #(.WIDTH(W), .DEPTH(DEPTH)) dut (
      .clk               (clk),
      .rst               (rst),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_write         (req_write),
      .req_size          (req_size),
      .req_signed        (req_signed),
      .req_addr          (req_addr),
      .req_wdata         (req_wdata),
      .resp_valid        (resp_valid),
      .resp_rdata        (resp_rdata),
      .resp_misaligned   (resp_misaligned),
      .mem_read          (mem_read),
      .mem_write         (mem_write),
      .mem_read_address  (mem_read_address),
      .mem_write_address (mem_write_address),
      .mem_write_data    (mem_write_data),
      .mem_data          (mem_data)
   );

   // Memory the DUT talks to: registered read, synchronous write.
   logic [W-1:0] tb_mem [DEPTH];
   always @(posedge clk) begin
      if (mem_read)  mem_data <= tb_mem[mem_read_address[9:0]];
      if (mem_write) tb_mem[mem_write_address[9:0]] <= mem_write_data;
   end

   // Expected outputs, one entry per cycle of an in-flight request.
   typedef struct {
      logic         rv;
      logic [W-1:0] rdata;
      logic         mis;
      logic         rd;
      logic [W-1:0] raddr;
      logic         wr;
      logic [W-1:0] waddr;
      logic [W-1:0] wdata;
   } cyc_t;

   cyc_t         exp_q[$];
   logic [W-1:0] ref_mem [DEPTH];
   int           n_vec = 0;
   int           n_err = 0;
   bit           chk_en = 1'b0;
   bit           acc_seen = 1'b0;
   bit           resp_seen = 1'b0;
   logic [W-1:0] last_rdata = '0;
   logic         last_mis = 1'b0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Predict the whole life of an accepted request from the access rules.
   task automatic model_accept(input logic w, input logic [1:0] sz, input logic sg,
                               input logic [W-1:0] a, input logic [W-1:0] d);
      cyc_t         idle_c, c;
      int           idx, sh;
      logic [W-1:0] old, val, mask;
      idle_c = '{default: '0};
      idx    = int'(a[11:2]);
      old    = ref_mem[idx];
      sh     = 0;
      mask   = '0;
      if (sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)) begin
         c = idle_c; c.rv = 1'b1; c.mis = 1'b1;
         exp_q.push_back(c);
      end else if (!w) begin
         if (sz == 2'b00) begin
            sh  = 8 * (3 - int'(a[1:0]));
            val = (old >> sh) & 32'hFF;
            if (sg && val[7]) val = val | 32'hFFFFFF00;
         end else if (sz == 2'b01) begin
            sh  = 16 * (1 - int'(a[1]));
            val = (old >> sh) & 32'hFFFF;
            if (sg && val[15]) val = val | 32'hFFFF0000;
         end else begin
            val = old;
         end
         c = idle_c; c.rd = 1'b1; c.raddr = 32'(idx);
         exp_q.push_back(c);
         exp_q.push_back(idle_c);
         c = idle_c; c.rv = 1'b1; c.rdata = val;
         exp_q.push_back(c);
      end else begin
         if (sz == 2'b10) begin
            val = d;
         end else begin
            if (sz == 2'b00) begin
               sh = 8 * (3 - int'(a[1:0])); mask = 32'hFF << sh;
            end else begin
               sh = 16 * (1 - int'(a[1])); mask = 32'hFFFF << sh;
            end
            val = (old & ~mask) | ((d << sh) & mask);
            c = idle_c; c.rd = 1'b1; c.raddr = 32'(idx);
            exp_q.push_back(c);
            exp_q.push_back(idle_c);
         end
         c = idle_c; c.wr = 1'b1; c.waddr = 32'(idx); c.wdata = val;
         exp_q.push_back(c);
         c = idle_c; c.rv = 1'b1;
         exp_q.push_back(c);
      end
   endtask

   // Single compare process: check this cycle, then advance the model.
   always @(negedge clk) begin
      cyc_t e;
      bit   idle;
      if (chk_en) begin
         idle = (exp_q.size() == 0);
         e    = '{default: '0};
         if (!idle) e = exp_q.pop_front();
         if (rst) begin
            e.wr = 1'b0; e.waddr = '0; e.wdata = '0;
         end
         chk("req_ready",         32'(req_ready),       32'(idle));
         chk("resp_valid",        32'(resp_valid),      32'(e.rv));
         chk("resp_rdata",        resp_rdata,           e.rdata);
         chk("resp_misaligned",   32'(resp_misaligned), 32'(e.mis));
         chk("mem_read",          32'(mem_read),        32'(e.rd));
         chk("mem_read_address",  mem_read_address,     e.raddr);
         chk("mem_write",         32'(mem_write),       32'(e.wr));
         chk("mem_write_address", mem_write_address,    e.waddr);
         chk("mem_write_data",    mem_write_data,       e.wdata);
         if (e.wr) ref_mem[e.waddr[9:0]] = e.wdata;
         if (resp_valid) begin
            last_rdata = resp_rdata;
            last_mis   = resp_misaligned;
            resp_seen  = 1'b1;
         end
         if (rst) begin
            exp_q.delete();
         end else if (idle && req_valid) begin
            model_accept(req_write, req_size, req_signed, req_addr, req_wdata);
            acc_seen = 1'b1;
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(posedge clk); #1; n++;
      end
      if (exp_q.size() != 0) begin
         n_vec++; n_err++;
         $display("FAIL idle_timeout: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic drive(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [W-1:0] a, input logic [W-1:0] d, input bit hold);
      int n = 0;
      req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = d;
      acc_seen = 1'b0;
      while (!acc_seen && n < 40) begin
         @(posedge clk); #1; n++;
      end
      if (!acc_seen) begin
         n_vec++; n_err++;
         $display("FAIL accept_timeout: got no accept expected accept within 40 cycles");
      end
      acc_seen = 1'b0;
      if (!hold) begin
         req_valid = 1'b0;
         wait_idle();
      end
   endtask

   task automatic req_chk(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [W-1:0] a, input logic [W-1:0] d,
                          input logic [W-1:0] lit_rdata, input logic lit_mis);
      resp_seen = 1'b0;
      drive(w, sz, sg, a, d, 1'b0);
      chk("lit_resp_seen", 32'(resp_seen), 32'd1);
      chk("lit_rdata",     last_rdata,     lit_rdata);
      chk("lit_mis",       32'(last_mis),  32'(lit_mis));
   endtask

   // Sub-byte store to 0x10 with reset on the given cycle after accept.
   task automatic sb_with_rst(input int stage);
      resp_seen = 1'b0;
      drive(1'b1, 2'b00, 1'b0, 32'h10, 32'h55, 1'b1);
      req_valid = 1'b0;
      repeat (stage - 1) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      wait_idle();
      chk("rst_no_resp", 32'(resp_seen), 32'd0);
      chk("rst_mem_kept", tb_mem[4], 32'h1234C3EE);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] v, a, d;
      logic         w, sg;
      logic [1:0]   sz;
      int           r;
      for (int i = 0; i < DEPTH; i++) begin
         v = $urandom; tb_mem[i] = v; ref_mem[i] = v;
      end
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;

      // Reset state.
      @(negedge clk);
      chk("rst_req_ready",  32'(req_ready),  32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_mem_read",   32'(mem_read),   32'd0);
      chk("rst_mem_write",  32'(mem_write),  32'd0);
      chk("rst_resp_rdata", resp_rdata,      32'd0);
      @(posedge clk); #1;

      // Word store, then loads of every flavour.
      req_chk(1'b1, 2'b10, 1'b0, 32'h10, 32'hA1B2C3D4, 32'h0, 1'b0);
      chk("sw_ref_mem", ref_mem[4], 32'hA1B2C3D4);
      chk("sw_tb_mem",  tb_mem[4],  32'hA1B2C3D4);
      req_chk(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'hFFFFFFB2, 1'b0);
      req_chk(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h000000B2, 1'b0);
      req_chk(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFFC3D4, 1'b0);
      req_chk(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h0000C3D4, 1'b0);
      req_chk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hA1B2C3D4, 1'b0);

      // Read-modify-write stores.
      req_chk(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000EE, 32'h0, 1'b0);
      chk("sb_ref_mem", ref_mem[4], 32'hA1B2C3EE);
      req_chk(1'b1, 2'b01, 1'b0, 32'h10, 32'h00001234, 32'h0, 1'b0);
      chk("sh_tb_mem", tb_mem[4], 32'h1234C3EE);
      req_chk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1234C3EE, 1'b0);

      // Faults, back to back with req_valid held.
      drive(1'b0, 2'b01, 1'b1, 32'h11, 32'h0, 1'b1);
      drive(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b1);
      resp_seen = 1'b0;
      drive(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0);
      chk("fault_resp_seen", 32'(resp_seen), 32'd1);
      chk("fault_mis",       32'(last_mis),  32'd1);
      chk("fault_rdata",     last_rdata,     32'd0);

      // Reset during MRG, then during WR.
      sb_with_rst(2);
      sb_with_rst(3);
      req_chk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1234C3EE, 1'b0);

      // Randomized traffic, with occasional held requests and reset pulses.
      for (int i = 0; i < 300; i++) begin
         w  = 1'($urandom_range(0, 1));
         sg = 1'($urandom_range(0, 1));
         r  = int'($urandom_range(0, 9));
         sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
         a  = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFFF000);
         d  = $urandom;
         if ($urandom_range(0, 15) == 0) begin
            drive(w, sz, sg, a, d, 1'b1);
            req_valid = 1'b0;
            repeat ($urandom_range(0, 4)) begin
               @(posedge clk); #1;
            end
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            wait_idle();
         end else begin
            drive(w, sz, sg, a, d, ($urandom_range(0, 3) == 0));
         end
      end
      req_valid = 1'b0;
      wait_idle();
      @(posedge clk); #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
